// File: rtl/dl_rr_arb8.sv
// ============================================================================
// dl_rr_arb8 : registered 8-way round-robin arbiter driving an 8:1 mux select
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module dl_rr_arb8 #(
    parameter int NUM_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            i_req,
    input  logic                  i_gnt_ready,
    input  logic [8*NUM_BITS-1:0] i_data_in,
    output logic                  o_gnt_valid,
    output logic [2:0]            o_gnt_idx,
    output logic [7:0]            o_gnt_onehot,
    output logic [NUM_BITS-1:0]   o_data_out
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     r_state;
    logic [2:0] r_ptr;
    logic       r_gnt_valid;
    logic [2:0] r_gnt_idx;
    logic [7:0] r_gnt_onehot;

    logic [2:0] w_xfer_ptr;
    logic       w_idle_found;
    logic [2:0] w_idle_idx;
    logic       w_xfer_found;
    logic [2:0] w_xfer_idx;

    // Returns {found, index}; descending offset loop lets the lowest offset
    // from the pointer win.
    function automatic logic [3:0] f_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        for (int i = 7; i >= 0; i--) begin
            idx = ptr + 3'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_xfer_ptr                 = r_gnt_idx + 3'd1;
    assign {w_idle_found, w_idle_idx} = f_pick(i_req, r_ptr);
    assign {w_xfer_found, w_xfer_idx} = f_pick(i_req, w_xfer_ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ptr        <= 3'd0;
            r_gnt_valid  <= 1'b0;
            r_gnt_idx    <= 3'd0;
            r_gnt_onehot <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_idle_found) begin
                        r_state      <= GRANT;
                        r_gnt_valid  <= 1'b1;
                        r_gnt_idx    <= w_idle_idx;
                        r_gnt_onehot <= 8'd1 << w_idle_idx;
                    end
                end
                GRANT: begin
                    // Sticky grant: only a completed handshake moves anything.
                    if (i_gnt_ready) begin
                        r_ptr <= w_xfer_ptr;
                        if (w_xfer_found) begin
                            r_gnt_idx    <= w_xfer_idx;
                            r_gnt_onehot <= 8'd1 << w_xfer_idx;
                        end else begin
                            r_state      <= IDLE;
                            r_gnt_valid  <= 1'b0;
                            r_gnt_onehot <= 8'd0;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_gnt_valid  = r_gnt_valid;
    assign o_gnt_idx    = r_gnt_idx;
    assign o_gnt_onehot = r_gnt_onehot;
    assign o_data_out   = i_data_in[r_gnt_idx*NUM_BITS +: NUM_BITS];

endmodule

`default_nettype wire

// File: tb/tb_dl_rr_arb8.sv
// ============================================================================
// tb_dl_rr_arb8 : directed and randomized checks of dl_rr_arb8 against a model
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dl_rr_arb8;

    localparam int NB = 32;

    logic          clk;
    logic          rst;
    logic [7:0]    req;
    logic          rdy;
    logic [8*NB-1:0] din;
    logic          gv;
    logic [2:0]    gi;
    logic [7:0]    goh;
    logic [NB-1:0] dout;

    int tests;
    int fails;

    // Reference state: grant valid flag, granted index, priority pointer
    int m_valid;
    int m_idx;
    int m_ptr;

    dl_rr_arb8 #(.NUM_BITS(NB)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (req),
        .i_gnt_ready  (rdy),
        .i_data_in    (din),
        .o_gnt_valid  (gv),
        .o_gnt_idx    (gi),
        .o_gnt_onehot (goh),
        .o_data_out   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        logic [7:0]    e_oh;
        logic [NB-1:0] e_d;
        e_oh = (m_valid != 0) ? (8'd1 << m_idx) : 8'd0;
        e_d  = din[m_idx*NB +: NB];
        chk({tag, ".valid"}, {31'd0, gv}, 32'(m_valid));
        chk({tag, ".idx"}, {29'd0, gi}, 32'(m_idx));
        chk({tag, ".onehot"}, {24'd0, goh}, {24'd0, e_oh});
        if (m_valid != 0) chk({tag, ".data"}, dout, e_d);
    endtask

    // Apply inputs for one cycle, advance the model on the edge, check after it.
    task automatic step(input logic [7:0] r, input logic y, input string tag);
        int w;
        req = r;
        rdy = y;
        @(posedge clk);
        if (m_valid == 0) begin
            w = ref_pick(r, m_ptr);
            if (w >= 0) begin
                m_valid = 1;
                m_idx   = w;
            end
        end else if (y) begin
            m_ptr = (m_idx + 1) % 8;
            w = ref_pick(r, m_ptr);
            if (w >= 0) m_idx = w;
            else m_valid = 0;
        end
        #1;
        chk_all(tag);
    endtask

    task automatic do_reset();
        req = 8'h00;
        rdy = 1'b0;
        rst = 1'b1;
        m_valid = 0;
        m_idx   = 0;
        m_ptr   = 0;
        @(posedge clk);
        #1;
        chk_all("reset");
        rst = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 8; i++) din[i*NB +: NB] = 32'hA000_0000 + 32'(i);
        rst = 1'b1;
        req = 8'h00;
        rdy = 1'b0;
        #2;
        do_reset();

        // Asynchronous reset in the middle of a grant to index 5
        step(8'h20, 1'b0, "pre_rst");
        chk("pre_rst.idx5", {29'd0, gi}, 32'd5);
        #3;
        rst = 1'b1;
        #1;
        m_valid = 0; m_idx = 0; m_ptr = 0;
        chk("async_rst.valid", {31'd0, gv}, 32'd0);
        chk("async_rst.idx", {29'd0, gi}, 32'd0);
        chk("async_rst.onehot", {24'd0, goh}, 32'd0);
        chk("async_rst.data", dout, 32'hA000_0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(8'h20, 1'b0, "post_rst");
        chk("post_rst.idx5", {29'd0, gi}, 32'd5);

        // Single requester re-granted after its own transfer
        do_reset();
        step(8'h08, 1'b0, "single0");
        chk("single.idx3", {29'd0, gi}, 32'd3);
        chk("single.oh", {24'd0, goh}, 32'h08);
        step(8'h08, 1'b1, "single1");
        chk("single.regrant", {29'd0, gi}, 32'd3);
        step(8'h00, 1'b1, "single2");
        chk("single.idle", {31'd0, gv}, 32'd0);

        // Full rotation with no bubbles
        do_reset();
        step(8'hFF, 1'b0, "rot_start");
        for (int k = 1; k <= 8; k++) begin
            step(8'hFF, 1'b1, "rot");
            chk("rot.seq", {29'd0, gi}, 32'(k % 8));
        end

        // Backpressure and stickiness
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step((k == 3) ? 8'h80 : 8'h81, 1'b0, "stall");
            chk("stall.idx0", {29'd0, gi}, 32'd0);
        end
        step(8'h80, 1'b1, "stall_rel");
        chk("stall_rel.idx7", {29'd0, gi}, 32'd7);

        // Wrap-around of the priority pointer
        do_reset();
        step(8'h40, 1'b0, "wrap0");
        step(8'h41, 1'b1, "wrap1");
        chk("wrap.idx0", {29'd0, gi}, 32'd0);
        step(8'h41, 1'b1, "wrap2");
        chk("wrap.idx6", {29'd0, gi}, 32'd6);

        // Data path tap
        do_reset();
        step(8'h10, 1'b0, "data");
        chk("data.slice4", dout, 32'hA000_0004);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [7:0] r;
            r = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
            if ($urandom_range(0, 7) == 0) r = 8'h00;
            if ($urandom_range(0, 9) == 0) din[$urandom_range(0, 7)*NB +: NB] = $urandom;
            step(r, 1'($urandom_range(0, 2) != 0), "rand");
            if ($urandom_range(0, 60) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/dl_rr_arb8.md
# dl_rr_arb8

Registered 8-way round-robin arbiter that produces the select index for the design library's 8-to-1 multiplexer. Up to eight requesters raise `req`. The arbiter picks one fairly and holds `gnt_idx` stable on the mux `sel` until a downstream consumer accepts the transfer with a valid/ready handshake. It sits directly upstream of the 8:1 data mux, for example in memory-port or writeback-bus sharing.

## Interface
- `NUM_BITS`, default 32: width of the optional data-path tap `data_out`. Matches the mux width.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `req`  input  8  per-requester request; bit i corresponds to mux input i.
- `gnt_ready`  input  1  downstream accepts the current grant this cycle.
- `data_in`  input  8*NUM_BITS  packed requester data; slice i is `[i*NUM_BITS +: NUM_BITS]`.
- `gnt_valid`  output  1  a grant is active.
- `gnt_idx`  output  3  winner index; drives the mux `sel`.
- `gnt_onehot`  output  8  one-hot form of `gnt_idx`; all zero when `gnt_valid` is 0.
- `data_out`  output  NUM_BITS  `data_in` slice selected by `gnt_idx`. Combinational from registered `gnt_idx`.

## Operation
- State: FSM {IDLE, GRANT}, plus 3-bit priority pointer `ptr` (highest-priority index).
- Reset values:
  - state = IDLE, `ptr` = 0
  - `gnt_valid` = 0, `gnt_idx` = 0, `gnt_onehot` = 0
  - `data_out` = slice 0
- Winner selection: first set bit of `req` scanning `ptr`, `ptr+1`, …, `ptr+7`, with index arithmetic modulo 8 (wraps 7→0).
- IDLE:
  - If `req` != 0: register winner into `gnt_idx`, set `gnt_valid` = 1, go to GRANT.
  - Else stay in IDLE with outputs unchanged (`gnt_valid` = 0).
- GRANT, `gnt_ready` = 0:
  - Hold `gnt_idx`, `gnt_onehot` and `gnt_valid` unchanged.
  - The grant is sticky: deassertion of `req[gnt_idx]` does not revoke it, and new requests do not preempt it.
- GRANT, `gnt_ready` = 1 (transfer):
  - `ptr` ← `gnt_idx + 1` (mod 8).
  - The winner is recomputed in the same cycle against `req` using the new pointer. The just-served requester therefore has lowest priority.
  - If a winner exists: load it, stay in GRANT (back-to-back grants, no bubble).
  - Else: `gnt_valid` ← 0, go to IDLE.
- `gnt_ready` is ignored in IDLE.
- Fairness: with all 8 requests held high and `gnt_ready` = 1 constantly, grants rotate 0,1,2,…,7,0,…
- `ptr` changes only on a transfer.

## Timing
- Request-to-grant latency:
  - `req` sampled at edge k (arbiter in IDLE) → `gnt_valid` = 1 and `gnt_idx` valid after edge k.
  - One cycle of latency; outputs are registered.
- Handshake: a transfer occurs on an edge where `gnt_valid` = 1 and `gnt_ready` = 1.
- Throughput: one grant per cycle under continuous `gnt_ready`.
- `gnt_idx`/`gnt_onehot` are glitch-free: they change only at clock edges.
- `data_out` follows `gnt_idx` through a combinational 8:1 select. It is valid whenever `gnt_valid` = 1.
- Reset mid-transfer: `rst` asserted at any time forces all reset values immediately (asynchronously). The pending grant is dropped and never counted as transferred.
- First arbitration after `rst` deasserts happens on the first rising edge with `rst` low.

## Test plan
- Reset: assert `rst` mid-GRANT with `gnt_idx` = 5 → `gnt_valid` = 0, `gnt_idx` = 0, `gnt_onehot` = 0 immediately, without waiting for a clock edge. After release with `req` = 8'h20 → grant idx 5 one cycle later.
- Single requester: `req` = 8'h08, `gnt_ready` = 1 from cycle 2 → `gnt_valid` rises 1 cycle after `req`, `gnt_idx` = 3, `gnt_onehot` = 8'h08. After the transfer, `ptr` = 4 and `gnt_idx` = 3 is re-granted while `req[3]` stays high.
- Full rotation: `req` = 8'hFF, `gnt_ready` = 1 → `gnt_idx` sequence 0,1,2,3,4,5,6,7,0 on consecutive cycles, with no idle cycles.
- Backpressure and stickiness: `req` = 8'h81, `gnt_ready` = 0 for 5 cycles → `gnt_idx` = 0 held for all 5 cycles. Dropping `req[0]` during the stall does not change the grant. Then `gnt_ready` = 1 for one cycle → next `gnt_idx` = 7.
- Wrap-around: `ptr` = 7 (after serving idx 6), `req` = 8'h41 → `gnt_idx` = 0 (scan 7→0). After the transfer `ptr` = 1, and `req` = 8'h41 → `gnt_idx` = 6.
- Data path: `NUM_BITS` = 32, slice i = 32'hA000_0000+i, `req` = 8'h10 → `data_out` = 32'hA000_0004 while `gnt_valid` = 1.
